sieve_engine: RTL and testbench

- Parametrised, restartable Sieve of Eratosthenes engine. Marks composites up to a runtime limit, bounded by the compile-time ceiling N_MAX.
- Marks from p*p and stops scanning bases once p*p > limit.
- Exposes the final prime bitmap and a prime count.
- Streams the primes in ascending order over a valid/ready interface to downstream consumers in the number-theory datapath.

---
 rtl/sieve_engine.sv | 133 +++++++++++++
 tb/tb_sieve_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sieve_engine.sv
// Restartable Sieve of Eratosthenes: marks composites up to a runtime limit, then streams primes.
// Define SIEVE_ODD_STRIDE_EN to skip even candidates/multiples (same results, fewer cycles).
module sieve_engine #(
  parameter int N_MAX = 100,
  parameter int W     = $clog2(N_MAX+1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W-1:0]     limit,
  output logic             busy,
  output logic             done,
  output logic [N_MAX:0]   is_prime,
  output logic [W-1:0]     prime_count,
  output logic             prime_valid,
  output logic [W-1:0]     prime_data,
  input  logic             prime_ready
);
  typedef enum logic [2:0] {IDLE, SCAN, MARK, STREAM, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     lim_r, p, m, i, count;
  logic [N_MAX:0]   composite;
  logic [W-1:0]     lim_clamp, p_nxt;
  logic [2*W-1:0]   pp;
  logic [W+1:0]     step, m_nxt;
  logic [W:0]       i_nxt;
  logic             p_over, mark_last, i_last, hs, accept;

  assign lim_clamp = (int'(limit) > N_MAX) ? W'(N_MAX) : limit;
  assign accept    = start && (state == IDLE || state == DONE);
  assign pp        = {{W{1'b0}}, p} * {{W{1'b0}}, p};
  assign p_over    = pp > {{W{1'b0}}, lim_r};

`ifdef SIEVE_ODD_STRIDE_EN
  // Even multiples are already covered by p=2, so odd bases step by 2p.
  assign step  = (p == W'(2)) ? {2'b00, p} : {1'b0, p, 1'b0};
  assign p_nxt = (p == W'(2)) ? W'(3) : p + W'(2);
  assign i_nxt = (i == W'(2)) ? (W+1)'(3) : {1'b0, i} + (W+1)'(2);
`else
  assign step  = {2'b00, p};
  assign p_nxt = p + W'(1);
  assign i_nxt = {1'b0, i} + (W+1)'(1);
`endif

  assign m_nxt     = {2'b00, m} + step;
  assign mark_last = m_nxt > {2'b00, lim_r};
  assign i_last    = i_nxt > {1'b0, lim_r};
  assign hs        = prime_valid && prime_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (lim_clamp < W'(2)) ? DONE : SCAN;
      SCAN:       if (p_over) state_nxt = STREAM;
                  else if (!composite[p]) state_nxt = MARK;
      MARK:       if (mark_last) state_nxt = SCAN;
      STREAM:     if ((composite[i] || hs) && i_last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    prime_valid = 1'b0;
    prime_data  = '0;
    case (state)
      SCAN, MARK: busy = 1'b1;
      STREAM: begin
        busy        = 1'b1;
        prime_valid = !composite[i];
        prime_data  = composite[i] ? '0 : i;
      end
      DONE:       done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lim_r     <= '0;
      p         <= '0;
      m         <= '0;
      i         <= '0;
      count     <= '0;
      composite <= '0;
    end else if (accept) begin
      lim_r     <= lim_clamp;
      p         <= W'(2);
      m         <= '0;
      i         <= W'(2);
      count     <= '0;
      composite <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (p_over)              i <= W'(2);
          else if (composite[p])   p <= p_nxt;
          else                     m <= pp[W-1:0];
        end
        MARK: begin
          composite[m] <= 1'b1;
          if (mark_last) p <= p_nxt;
          else           m <= m_nxt[W-1:0];
        end
        STREAM: begin
          if (composite[i] || hs) begin
            if (hs)      count <= count + W'(1);
            if (!i_last) i     <= i_nxt[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign prime_count = done ? count : '0;

  for (genvar k = 0; k <= N_MAX; k++) begin : g_bit
    if (k < 2) begin : g_zero
      assign is_prime[k] = 1'b0;
    end else begin : g_live
      assign is_prime[k] = done && !composite[k] && (W'(k) <= lim_r);
    end
  end

endmodule

// File: tb/tb_sieve_engine.sv
// Scoreboard bench for sieve_engine: expected primes queued at start, popped by a stream monitor.
module tb_sieve_engine;
  localparam int N_MAX = 100;
  localparam int W     = $clog2(N_MAX+1);

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     limit = '0;
  logic             prime_ready = 1'b1;
  logic             busy, done, prime_valid;
  logic [N_MAX:0]   is_prime;
  logic [W-1:0]     prime_count, prime_data;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_n;
  logic [127:0] exp_mask;
  int primes[25] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47,
                     53, 59, 61, 67, 71, 73, 79, 83, 89, 97};

  bit   stall_en = 1'b0;
  int   stall_n  = 0;
  bit   hold_v   = 1'b0;
  logic [W-1:0] hold_d;

  sieve_engine #(.N_MAX(N_MAX)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .limit(limit),
    .busy(busy), .done(done), .is_prime(is_prime), .prime_count(prime_count),
    .prime_valid(prime_valid), .prime_data(prime_data), .prime_ready(prime_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: stalls for 5 cycles while 7 is presented, when enabled.
  always @(posedge clock) begin
    #1;
    if (stall_en && prime_valid && prime_data == W'(7) && stall_n < 5) begin
      prime_ready = 1'b0;
      stall_n++;
    end else begin
      prime_ready = 1'b1;
    end
  end

  // Stream monitor
  always @(negedge clock) begin
    if (reset_n) begin
      if (hold_v) chk("stream_hold", {prime_valid, prime_data}, {1'b1, hold_d});
      hold_v = prime_valid && !prime_ready;
      hold_d = prime_data;
      if (prime_valid && prime_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got prime %0d expected no output", prime_data);
        end else begin
          chk("stream_data", prime_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic launch(input int lim);
    int eff;
    eff      = (lim > N_MAX) ? N_MAX : lim;
    exp_n    = 0;
    exp_mask = '0;
    foreach (primes[k]) if (primes[k] <= eff) begin
      exp_q.push_back(primes[k]);
      exp_mask[primes[k]] = 1'b1;
      exp_n++;
    end
    @(posedge clock); #1;
    limit = W'(lim);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic finish(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_count"}, prime_count, exp_n);
    chk({tag, "_is_prime"}, is_prime, exp_mask);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_is_prime", is_prime, 0);
    chk("rst_count", prime_count, 0);
    chk("rst_valid", prime_valid, 1'b0);
    chk("rst_data", prime_data, 0);
    reset_n = 1'b1;

    launch(100);
    finish("lim100", cyc);
`ifdef SIEVE_ODD_STRIDE_EN
    chk("lim100_cycles", cyc, 133);
`else
    chk("lim100_cycles", cyc, 213);
`endif
    chk("is_prime97", is_prime[97], 1'b1);
    chk("is_prime91", is_prime[91], 1'b0);
    chk("is_prime1", is_prime[1], 1'b0);

    launch(1);
    finish("lim1", cyc);
    chk("lim1_within2", cyc <= 2, 1'b1);

    stall_n  = 0;
    stall_en = 1'b1;
    launch(30);
    finish("lim30", cyc);
    stall_en = 1'b0;
    chk("lim30_stalls", stall_n, 5);

    launch(127);
    finish("lim127", cyc);

    launch(2);
    finish("lim2", cyc);

    // Start pulse while marking multiples of 2 must be ignored.
    launch(100);
    repeat (3) @(posedge clock);
    #1;
    limit = W'(10);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    finish("midmark", cyc);

    // Async reset while streaming.
    launch(100);
    for (int t = 0; t < 1000 && !(prime_valid && prime_data == W'(13)); t++) begin
      @(posedge clock); #1;
    end
    chk("reach13", prime_data, 13);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_valid", prime_valid, 1'b0);
    chk("arst_data", prime_data, 0);
    chk("arst_count", prime_count, 0);
    chk("arst_is_prime", is_prime, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);

    launch(10);
    finish("lim10", cyc);

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
